// File: rtl/seq_mul_ctrl_pkg.sv
// Shared types and decode helpers for the shift-add multiplier control unit.
package seq_mul_ctrl_pkg;

   localparam int unsigned WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_ITER = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Moore strobes toward the register bank and adder gating
   typedef struct packed {
      logic start;
      logic ld;
      logic acc_zero;
      logic busy;
   } strobe_t;

   // Holding go makes DONE chain straight into the next LOAD
   function automatic state_t fsm_next(input state_t s, input logic go, input logic last);
      state_t n;
      n = S_IDLE;
      case (s)
         S_IDLE:  n = go ? S_LOAD : S_IDLE;
         S_LOAD:  n = S_ITER;
         S_ITER:  n = last ? S_DONE : S_ITER;
         S_DONE:  n = go ? S_LOAD : S_IDLE;
         default: n = S_IDLE;
      endcase
      return n;
   endfunction

   function automatic strobe_t decode_strobes(input state_t s);
      strobe_t r;
      r = '0;
      case (s)
         S_LOAD: begin
            r.start    = 1'b1;
            r.ld       = 1'b1;
            r.acc_zero = 1'b1;
            r.busy     = 1'b1;
         end
         S_ITER: begin
            r.ld   = 1'b1;
            r.busy = 1'b1;
         end
         S_DONE:  r.busy = 1'b1;
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seq_mul_ctrl_iter_cnt.sv
// Iteration counter: synchronous clear/enable, flags the final add/shift step.
module mul_iter_cnt
   import seq_mul_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned CNT_W = $clog2(WIDTH)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic last_c
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign last_c = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/seq_mul_ctrl.sv
// Control unit for the shift-add sequential multiplier: sequences load, WIDTH
// add/shift iterations and product capture, then pulses done.
module seq_mul_ctrl
   import seq_mul_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned CNT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               go,
   input  logic [2*WIDTH:0]   p,
   output logic               start,
   output logic               ld,
   output logic               acc_zero,
   output logic               add_sel,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   state_t  state;
   state_t  nxt_c;
   strobe_t strb;
   logic    last_c;
   logic    unused_carry;

   mul_iter_cnt #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (state == S_LOAD),
      .en     (state == S_ITER),
      .last_c (last_c)
   );

   assign nxt_c = fsm_next(state, go, last_c);

   // Strobes are registered from the next state so they line up with it
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         strb    <= '0;
         done    <= 1'b0;
         product <= '0;
      end else begin
         state <= nxt_c;
         strb  <= decode_strobes(nxt_c);
         done  <= (state == S_DONE);
         if (state == S_DONE) begin
            product <= p[2*WIDTH-1:0];
         end
      end
   end

   assign start    = strb.start;
   assign ld       = strb.ld;
   assign acc_zero = strb.acc_zero;
   assign busy     = strb.busy;

   // Multiplicand gating follows the live bank LSB, only while iterating
   assign add_sel  = (state == S_ITER) & p[0];

   // The carry bit only matters to the datapath; the product is taken below it
   assign unused_carry = p[2*WIDTH];

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Bench: controller driving a 9-bit register bank and 4-bit adder, products scoreboarded.
module tb_seq_mul_ctrl;

   localparam int unsigned W = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           go;
   logic [2*W:0]   p;
   logic           start, ld, acc_zero, add_sel, busy, done;
   logic [2*W-1:0] product;

   logic [W-1:0]   a, b;
   logic [W-1:0]   add_a, add_b, sum_c;
   logic           cy;

   int             total = 0;
   int             bad   = 0;
   logic [7:0]     sb_q[$];
   logic [7:0]     last_prod;
   int             cyc;

   always #5 clk = ~clk;

   seq_mul_ctrl #(.WIDTH(W), .CNT_W(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .go       (go),
      .p        (p),
      .start    (start),
      .ld       (ld),
      .acc_zero (acc_zero),
      .add_sel  (add_sel),
      .busy     (busy),
      .done     (done),
      .product  (product)
   );

   // Datapath: {carry, acc, multiplier}; add then shift the whole word right
   assign add_a       = acc_zero ? '0 : p[7:4];
   assign add_b       = add_sel ? a : '0;
   assign {cy, sum_c} = 5'(add_a) + 5'(add_b);

   always_ff @(posedge clk) begin
      if (rst)        p <= '0;
      else if (start) p <= {5'b0, b};
      else if (ld)    p <= {1'b0, cy, sum_c, p[3:1]};
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // {start, ld, acc_zero, add_sel, busy, done}
   task automatic chk_strb(input string tag, input logic [5:0] exp);
      chk(tag, 16'({start, ld, acc_zero, add_sel, busy, done}), 16'(exp));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pop_cmp(input string tag);
      logic [7:0] e;
      chk({tag, "_sb"}, 16'(sb_q.size() != 0), 16'(1));
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         chk(tag, 16'(product), 16'(e));
         last_prod = e;
      end
   endtask

   task automatic wait_done(input int limit, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (done !== 1'b1 && n < limit);
      chk("done_seen", 16'(done), 16'(1));
   endtask

   // Single multiply with full strobe-sequence checks; optional go pulse mid-ITER
   task automatic mul_once(input logic [3:0] ai, input logic [3:0] bi, input logic glitch);
      a  = ai;
      b  = bi;
      go = 1'b1;
      sb_q.push_back(8'(8'(ai) * 8'(bi)));
      tick();
      go = 1'b0;
      chk_strb("load", 6'b111010);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_strb("iter", {3'b010, bi[i], 2'b10});
         if (glitch && i == 1) go = 1'b1;
         if (i == 2) go = 1'b0;
      end
      tick();
      chk_strb("done_state", 6'b000010);
      tick();
      chk_strb("done_pulse", 6'b000001);
      pop_cmp("product");
      tick();
      chk_strb("idle_after", 6'b000000);
      repeat (2) tick();
      chk("product_hold", 16'(product), 16'(last_prod));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      go  = 1'b1;
      a   = '0;
      b   = '0;

      // Reset held with go asserted
      repeat (3) begin
         tick();
         chk_strb("rst_strobes", 6'b000000);
         chk("rst_product", 16'(product), 16'(0));
      end
      rst = 1'b0;
      go  = 1'b0;
      tick();
      chk_strb("post_rst_idle", 6'b000000);

      mul_once(4'd5, 4'd3, 1'b0);
      mul_once(4'd15, 4'd15, 1'b0);
      mul_once(4'd0, 4'd9, 1'b0);
      mul_once(4'd7, 4'd0, 1'b1);

      // Back-to-back with go held: done coincides with next LOAD
      a  = 4'd6;
      b  = 4'd7;
      sb_q.push_back(8'd42);
      go = 1'b1;
      wait_done(12, cyc);
      chk("b2b_lat1", 16'(cyc), 16'(7));
      chk_strb("b2b_load1", 6'b111011);
      pop_cmp("b2b_p1");
      a = 4'd9;
      b = 4'd9;
      sb_q.push_back(8'd81);
      wait_done(12, cyc);
      chk("b2b_lat2", 16'(cyc), 16'(6));
      chk_strb("b2b_load2", 6'b111011);
      pop_cmp("b2b_p2");
      a  = 4'd1;
      b  = 4'd1;
      go = 1'b0;
      sb_q.push_back(8'd1);
      wait_done(12, cyc);
      chk("b2b_lat3", 16'(cyc), 16'(6));
      chk_strb("b2b_last", 6'b000001);
      pop_cmp("b2b_p3");
      tick();
      chk_strb("b2b_idle", 6'b000000);

      // Reset in the second ITER cycle abandons the multiply
      a  = 4'd11;
      b  = 4'd13;
      go = 1'b1;
      tick();
      go = 1'b0;
      tick();
      tick();
      chk_strb("iter2_before_rst", {3'b010, 1'b0, 2'b10});
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_strb("abort_strobes", 6'b000000);
      chk("abort_product", 16'(product), 16'(0));
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("abort_no_done", 16'(done), 16'(0));
      end
      mul_once(4'd11, 4'd13, 1'b0);

      chk("sb_drained", 16'(sb_q.size()), 16'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
